// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage signed int32 -> IEEE-754 single converter, round-to-nearest-even, valid/ready with tag passthrough
module itof_pipe #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);
    logic             w_stall;
    logic [4:0]       w_lz;
    logic [30:0]      w_norm;
    logic             w_rnd;
    logic [23:0]      w_sum;
    logic [7:0]       w_exp;
    logic             r_s1_v, r_s1_sign, r_s1_zero;
    logic [TAG_W-1:0] r_s1_tag;
    logic [31:0]      r_s1_mag;
    logic             r_s2_v, r_s2_sign, r_s2_zero;
    logic [TAG_W-1:0] r_s2_tag;
    logic [30:0]      r_s2_m;
    logic [7:0]       r_s2_exp;
    logic             r_s3_v;
    logic [TAG_W-1:0] r_s3_tag;
    logic [31:0]      r_s3_data;

    assign w_stall   = r_s3_v & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_s3_v;
    assign out_data  = r_s3_data;
    assign out_tag   = r_s3_tag;

    // S1: split sign and magnitude; 0x80000000 maps onto itself as an unsigned magnitude
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_tag  <= '0;
            r_s1_sign <= 1'b0;
            r_s1_zero <= 1'b0;
            r_s1_mag  <= '0;
        end else if (!w_stall) begin
            r_s1_v    <= in_valid;
            r_s1_tag  <= in_tag;
            r_s1_sign <= in_data[31];
            r_s1_zero <= in_data == 32'd0;
            r_s1_mag  <= in_data[31] ? ~in_data + 32'd1 : in_data;
        end
    end

    // leading-zero count: the highest set bit wins; a zero magnitude leaves lz at 0
    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 32; i++) if (r_s1_mag[i]) w_lz = 5'(31 - i);
    end

    // bit 31 of the normalized value is the implicit one, so only the bits below it are kept
    assign w_norm = 31'(r_s1_mag << w_lz);

    // S2: normalize and derive the biased exponent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_v    <= 1'b0;
            r_s2_tag  <= '0;
            r_s2_sign <= 1'b0;
            r_s2_zero <= 1'b0;
            r_s2_m    <= '0;
            r_s2_exp  <= '0;
        end else if (!w_stall) begin
            r_s2_v    <= r_s1_v;
            r_s2_tag  <= r_s1_tag;
            r_s2_sign <= r_s1_sign;
            r_s2_zero <= r_s1_zero;
            r_s2_m    <= w_norm;
            r_s2_exp  <= 8'd158 - {3'b0, w_lz};
        end
    end

    assign w_rnd = r_s2_m[7] & ((|r_s2_m[6:0]) | r_s2_m[8]);
    assign w_sum = {1'b0, r_s2_m[30:8]} + {23'b0, w_rnd};
    assign w_exp = r_s2_exp + {7'b0, w_sum[23]};

    // S3: round to nearest even and pack; a carry out of the fraction bumps the exponent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_v    <= 1'b0;
            r_s3_tag  <= '0;
            r_s3_data <= '0;
        end else if (!w_stall) begin
            r_s3_v    <= r_s2_v;
            r_s3_tag  <= r_s2_tag;
            r_s3_data <= r_s2_zero ? 32'd0 : {r_s2_sign, w_exp, w_sum[22:0]};
        end
    end
endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed vectors, streaming, back-pressure, bubbles and reset checks for itof_pipe
module tb_itof_pipe;
    localparam int TW = 6;
    localparam int NV = 12;

    typedef struct {
        logic [31:0]   d;
        logic [TW-1:0] t;
        logic [31:0]   e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [31:0]   in_data = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready, out_valid;
    logic [31:0]   out_data;
    logic [TW-1:0] out_tag;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0, n_in = 0, n_out = 0, first_out = -1, last_out = -1;
    logic [31:0]   q_data[$];
    logic [TW-1:0] q_tag[$];
    vec_t          vecs[NV];
    logic          took;
    logic          bub;

    always #5 clk = ~clk;

    itof_pipe #(.TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    // reference: locate the top bit, shift right, then compare the remainder against one half
    function automatic logic [31:0] model(input logic [31:0] x);
        logic s;
        longint unsigned a, q, r, h;
        int p, sh;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        a = s ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        p = 31;
        while (((a >> p) & 64'd1) == 64'd0) p--;
        if (p <= 23) q = a << (23 - p);
        else begin
            sh = p - 23;
            q = a >> sh;
            r = a - (q << sh);
            h = 64'd1 << (sh - 1);
            if (r > h || (r == h && (q & 64'd1) == 64'd1)) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                p++;
            end
        end
        return {s, 8'(p + 127), q[22:0]};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: predicts transfers at the next rising edge from values stable at the falling edge
    task automatic monitor();
        logic [31:0]   ed;
        logic [TW-1:0] et;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cyc++;
                if (out_valid && out_ready) begin
                    n_out++;
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                    checks++;
                    if (q_data.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out: got %h tag %h want no result", out_data, out_tag);
                    end else begin
                        ed = q_data.pop_front();
                        et = q_tag.pop_front();
                        if (out_data !== ed || out_tag !== et) begin
                            errors++;
                            $display("FAIL sb_out: got %h tag %h want %h tag %h", out_data, out_tag, ed, et);
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    n_in++;
                    q_data.push_back(model(in_data));
                    q_tag.push_back(in_tag);
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 30 && q_data.size() != 0; k++) tick();
        tick();
        check32({name, "_drain_left"}, 32'(q_data.size()), 32'd0);
    endtask

    task automatic send(input logic [31:0] d, input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        tick();
    endtask

    initial begin
        vecs[0]  = '{32'd1,        6'd1,  32'h3F800000};
        vecs[1]  = '{32'hFFFFFFFF, 6'd2,  32'hBF800000};
        vecs[2]  = '{32'd0,        6'd3,  32'h00000000};
        vecs[3]  = '{32'd16777217, 6'd4,  32'h4B800000};
        vecs[4]  = '{32'd16777219, 6'd5,  32'h4B800002};
        vecs[5]  = '{32'h7FFFFFFF, 6'd6,  32'h4F000000};
        vecs[6]  = '{32'h80000000, 6'd7,  32'hCF000000};
        vecs[7]  = '{32'd2,        6'd8,  32'h40000000};
        vecs[8]  = '{32'd3,        6'd9,  32'h40400000};
        vecs[9]  = '{32'hFFFFFF00, 6'd10, 32'hC3800000};
        vecs[10] = '{32'd100,      6'd11, 32'h42C80000};
        vecs[11] = '{32'h00FFFFFF, 6'd12, 32'h4B7FFFFF};
        fork
            monitor();
        join_none
        repeat (3) tick();
        check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check32("rst_out_data", out_data, 32'd0);
        check32("rst_out_tag", 32'(out_tag), 32'd0);
        check32("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // directed table: valid stays low after the accepting edge and the next, rises after the third
        for (int i = 0; i < NV; i++) begin
            check32("vec_in_ready", {31'd0, in_ready}, 32'd1);
            send(vecs[i].d, vecs[i].t);
            in_valid = 1'b0;
            check32("vec_lat1", {31'd0, out_valid}, 32'd0);
            tick();
            check32("vec_lat2", {31'd0, out_valid}, 32'd0);
            tick();
            check32("vec_lat3", {31'd0, out_valid}, 32'd1);
            check32("vec_data", out_data, vecs[i].e);
            check32("vec_tag", 32'(out_tag), 32'(vecs[i].t));
            tick();
        end
        wait_drain("vec");

        // streaming: 100 back-to-back operands must leave on 100 consecutive cycles
        n_out = 0;
        first_out = -1;
        for (int i = 0; i < 100; i++) send($urandom, TW'($urandom));
        in_valid = 1'b0;
        wait_drain("stream");
        check32("stream_count", 32'(n_out), 32'd100);
        check32("stream_span", 32'(last_out - first_out), 32'd99);

        // back-pressure: three in flight, a fourth presented during a 5-cycle stall
        out_ready = 1'b0;
        send(32'd1000, 6'd21);
        send(32'hFFFFFFFB, 6'd22);
        send(32'd7, 6'd23);
        in_valid = 1'b1;
        in_data  = 32'd9;
        in_tag   = 6'd24;
        for (int k = 0; k < 5; k++) begin
            check32("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check32("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check32("bp_hold_data", out_data, 32'h447A0000);
            check32("bp_hold_tag", 32'(out_tag), 32'd21);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check32("bp_drain_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        wait_drain("bp");

        // bubbles: alternate in_valid, random out_ready, held operands stay put until taken
        n_in = 0;
        n_out = 0;
        took = 1'b1;
        bub = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!in_valid || took) begin
                bub = ~bub;
                in_valid = bub;
                in_data  = $urandom;
                in_tag   = TW'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            took = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain("bub");
        check32("bub_in_eq_out", 32'(n_out), 32'(n_in));

        // reset mid-flight: one result at the output, one more in S1
        out_ready = 1'b0;
        send(32'd42, 6'd31);
        in_valid = 1'b0;
        tick();
        send(32'd43, 6'd32);
        in_valid = 1'b0;
        check32("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check32("mid_out_valid", {31'd0, out_valid}, 32'd0);
        check32("mid_out_data", out_data, 32'd0);
        check32("mid_out_tag", 32'(out_tag), 32'd0);
        check32("mid_in_ready", {31'd0, in_ready}, 32'd1);
        q_data.delete();
        q_tag.delete();
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check32("mid_stale_valid", {31'd0, out_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
